axi_modport_register_slice: RTL and testbench

Full-throughput AXI4 register slice. It has an `axi_channel.slave` modport on the upstream side and an `axi_channel.master` modport on the downstream side. Every one of the five channels (AW, W, B, AR, R) passes through a 2-entry skid buffer, so no combinational path crosses the block. It is inserted between interconnect stages to break timing paths without losing bandwidth.

---
 rtl/axi_modport_register_slice_if.sv | 97 +++++++++
 rtl/axi_modport_register_slice.sv | 165 ++++++++++++++++
 tb/tb_axi_modport_register_slice.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_modport_register_slice_if.sv
// axi_channel: AXI4 bundle carrying the five channels (AW, W, B, AR, R).
// The master modport drives AW/W/AR payload and valid, plus the B/R readys.
// The slave modport drives the AW/W/AR readys, plus B/R payload and valid.
// clk/rstn are carried for neighbours that need them; the register slice
// clocks and resets from its own scalar ports instead.
interface axi_channel #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int R_USER_WIDTH  = 1
);
  logic clk;
  logic rstn;

  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDR_WIDTH-1:0]    aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic                     aw_lock;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [3:0]               aw_region;
  logic [AW_USER_WIDTH-1:0] aw_user;
  logic                     aw_valid;
  logic                     aw_ready;

  logic [DATA_WIDTH-1:0]    w_data;
  logic [DATA_WIDTH/8-1:0]  w_strb;
  logic                     w_last;
  logic [W_USER_WIDTH-1:0]  w_user;
  logic                     w_valid;
  logic                     w_ready;

  logic [ID_WIDTH-1:0]      b_id;
  logic [1:0]               b_resp;
  logic [B_USER_WIDTH-1:0]  b_user;
  logic                     b_valid;
  logic                     b_ready;

  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDR_WIDTH-1:0]    ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic                     ar_lock;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [3:0]               ar_region;
  logic [AR_USER_WIDTH-1:0] ar_user;
  logic                     ar_valid;
  logic                     ar_ready;

  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic [R_USER_WIDTH-1:0]  r_user;
  logic                     r_valid;
  logic                     r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_modport_register_slice.sv
// axi_modport_register_slice: full-throughput AXI4 register slice.
// Every channel passes through a 2-entry skid buffer so that valid, ready and
// payload on both sides come straight from flops.
// Ports:
//   clk  - clock for all state
//   rst  - synchronous active-high reset (control state only)
//   s    - upstream bundle (slave modport): accepts AW/W/AR, returns B/R
//   m    - downstream bundle (master modport): issues AW/W/AR, accepts B/R

// Skid buffer: output register plus one overflow entry. in_ready_o is the
// registered inverse of next-cycle skid occupancy, which is what lets the
// upstream keep streaming for one cycle after out_ready_i drops.
module axi_modport_register_slice_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire;
  logic              out_load;

  assign in_fire  = in_valid_i & in_ready_q;
  // Output register may take a new beat when empty or being drained.
  assign out_load = ~out_valid_q | out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_load) begin
      // The skid entry is older than any incoming beat, so it goes first.
      out_valid_d  = skid_valid_q | in_fire;
      out_data_d   = skid_valid_q ? skid_data_q : in_data_i;
      skid_valid_d = skid_valid_q & in_fire;
      if (skid_valid_q & in_fire) begin
        skid_data_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  // Payload flops carry no reset; their contents only matter under valid.
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
endmodule

module axi_modport_register_slice #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int R_USER_WIDTH  = 1
) (
  input  logic        clk,
  input  logic        rst,
  axi_channel.slave   s,
  axi_channel.master  m
);
  // AW/AR: len 8 + size 3 + burst 2 + lock 1 + cache 4 + prot 3 + qos 4 + region 4.
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 29 + AW_USER_WIDTH;
  localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 29 + AR_USER_WIDTH;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + W_USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + B_USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + R_USER_WIDTH;

  if ($bits(s.aw_id) != ID_WIDTH || $bits(m.aw_id) != ID_WIDTH ||
      $bits(s.aw_addr) != ADDR_WIDTH || $bits(m.aw_addr) != ADDR_WIDTH ||
      $bits(s.w_data) != DATA_WIDTH || $bits(m.w_data) != DATA_WIDTH ||
      $bits(s.aw_user) != AW_USER_WIDTH || $bits(m.aw_user) != AW_USER_WIDTH ||
      $bits(s.w_user) != W_USER_WIDTH || $bits(m.w_user) != W_USER_WIDTH ||
      $bits(s.b_user) != B_USER_WIDTH || $bits(m.b_user) != B_USER_WIDTH ||
      $bits(s.ar_user) != AR_USER_WIDTH || $bits(m.ar_user) != AR_USER_WIDTH ||
      $bits(s.r_user) != R_USER_WIDTH || $bits(m.r_user) != R_USER_WIDTH) begin : g_bad_bundle
    $fatal(1, "axi_modport_register_slice: bundle parameters differ from block parameters");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 ||
      (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
    $fatal(1, "axi_modport_register_slice: DATA_WIDTH must be a power of 2 in 8..1024");
  end

  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in,  w_out;
  logic [B_W-1:0]  b_in,  b_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in,  r_out;

  assign aw_in = {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_lock,
                  s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user};
  assign {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst, m.aw_lock,
          m.aw_cache, m.aw_prot, m.aw_qos, m.aw_region, m.aw_user} = aw_out;

  assign w_in = {s.w_data, s.w_strb, s.w_last, s.w_user};
  assign {m.w_data, m.w_strb, m.w_last, m.w_user} = w_out;

  assign b_in = {m.b_id, m.b_resp, m.b_user};
  assign {s.b_id, s.b_resp, s.b_user} = b_out;

  assign ar_in = {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_lock,
                  s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user};
  assign {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst, m.ar_lock,
          m.ar_cache, m.ar_prot, m.ar_qos, m.ar_region, m.ar_user} = ar_out;

  assign r_in = {m.r_id, m.r_data, m.r_resp, m.r_last, m.r_user};
  assign {s.r_id, s.r_data, s.r_resp, s.r_last, s.r_user} = r_out;

  axi_modport_register_slice_skid #(.DATA_W(AW_W)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid_i(s.aw_valid), .in_ready_o(s.aw_ready), .in_data_i(aw_in),
    .out_valid_o(m.aw_valid), .out_ready_i(m.aw_ready), .out_data_o(aw_out));

  axi_modport_register_slice_skid #(.DATA_W(W_W)) u_w (
    .clk(clk), .rst(rst),
    .in_valid_i(s.w_valid), .in_ready_o(s.w_ready), .in_data_i(w_in),
    .out_valid_o(m.w_valid), .out_ready_i(m.w_ready), .out_data_o(w_out));

  axi_modport_register_slice_skid #(.DATA_W(B_W)) u_b (
    .clk(clk), .rst(rst),
    .in_valid_i(m.b_valid), .in_ready_o(m.b_ready), .in_data_i(b_in),
    .out_valid_o(s.b_valid), .out_ready_i(s.b_ready), .out_data_o(b_out));

  axi_modport_register_slice_skid #(.DATA_W(AR_W)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid_i(s.ar_valid), .in_ready_o(s.ar_ready), .in_data_i(ar_in),
    .out_valid_o(m.ar_valid), .out_ready_i(m.ar_ready), .out_data_o(ar_out));

  axi_modport_register_slice_skid #(.DATA_W(R_W)) u_r (
    .clk(clk), .rst(rst),
    .in_valid_i(m.r_valid), .in_ready_o(m.r_ready), .in_data_i(r_in),
    .out_valid_o(s.r_valid), .out_ready_i(s.r_ready), .out_data_o(r_out));
endmodule

// File: tb/tb_axi_modport_register_slice.sv
// Self-checking bench for axi_modport_register_slice. The reference model
// treats each channel as a bounded FIFO of depth 2: valid on the far side
// means the FIFO is non-empty, ready on the near side means fewer than two
// beats are held, and the far-side payload is the oldest beat.
module tb_axi_modport_register_slice;
  typedef struct packed {
    logic [7:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ax_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic       user;
  } b_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64),
                .AW_USER_WIDTH(1), .W_USER_WIDTH(1), .B_USER_WIDTH(1),
                .AR_USER_WIDTH(1), .R_USER_WIDTH(1)) bus_s ();
  axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64),
                .AW_USER_WIDTH(1), .W_USER_WIDTH(1), .B_USER_WIDTH(1),
                .AR_USER_WIDTH(1), .R_USER_WIDTH(1)) bus_m ();

  assign bus_s.clk  = clk;
  assign bus_s.rstn = ~rst;
  assign bus_m.clk  = clk;
  assign bus_m.rstn = ~rst;

  axi_modport_register_slice #(
    .ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64),
    .AW_USER_WIDTH(1), .W_USER_WIDTH(1), .B_USER_WIDTH(1),
    .AR_USER_WIDTH(1), .R_USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(bus_s),
    .m(bus_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] far_valids();
    return {bus_m.aw_valid, bus_m.w_valid, bus_m.ar_valid, bus_s.b_valid, bus_s.r_valid};
  endfunction

  function automatic logic [4:0] near_readys();
    return {bus_s.aw_ready, bus_s.w_ready, bus_s.ar_ready, bus_m.b_ready, bus_m.r_ready};
  endfunction

  function automatic ax_t rand_ax();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[$bits(ax_t)-1:0];
  endfunction

  function automatic ax_t get_m_aw();
    return {bus_m.aw_id, bus_m.aw_addr, bus_m.aw_len, bus_m.aw_size, bus_m.aw_burst,
            bus_m.aw_lock, bus_m.aw_cache, bus_m.aw_prot, bus_m.aw_qos,
            bus_m.aw_region, bus_m.aw_user};
  endfunction

  function automatic ax_t get_m_ar();
    return {bus_m.ar_id, bus_m.ar_addr, bus_m.ar_len, bus_m.ar_size, bus_m.ar_burst,
            bus_m.ar_lock, bus_m.ar_cache, bus_m.ar_prot, bus_m.ar_qos,
            bus_m.ar_region, bus_m.ar_user};
  endfunction

  function automatic w_t get_m_w();
    return {bus_m.w_data, bus_m.w_strb, bus_m.w_last, bus_m.w_user};
  endfunction

  function automatic b_t get_s_b();
    return {bus_s.b_id, bus_s.b_resp, bus_s.b_user};
  endfunction

  function automatic r_t get_s_r();
    return {bus_s.r_id, bus_s.r_data, bus_s.r_resp, bus_s.r_last, bus_s.r_user};
  endfunction

  task automatic drive_s_aw(input ax_t a);
    {bus_s.aw_id, bus_s.aw_addr, bus_s.aw_len, bus_s.aw_size, bus_s.aw_burst,
     bus_s.aw_lock, bus_s.aw_cache, bus_s.aw_prot, bus_s.aw_qos,
     bus_s.aw_region, bus_s.aw_user} = a;
  endtask

  task automatic drive_s_ar(input ax_t a);
    {bus_s.ar_id, bus_s.ar_addr, bus_s.ar_len, bus_s.ar_size, bus_s.ar_burst,
     bus_s.ar_lock, bus_s.ar_cache, bus_s.ar_prot, bus_s.ar_qos,
     bus_s.ar_region, bus_s.ar_user} = a;
  endtask

  task automatic drive_s_w(input w_t w);
    {bus_s.w_data, bus_s.w_strb, bus_s.w_last, bus_s.w_user} = w;
  endtask

  task automatic drive_m_b(input b_t b);
    {bus_m.b_id, bus_m.b_resp, bus_m.b_user} = b;
  endtask

  task automatic drive_m_r(input r_t r);
    {bus_m.r_id, bus_m.r_data, bus_m.r_resp, bus_m.r_last, bus_m.r_user} = r;
  endtask

  task automatic init_inputs();
    drive_s_aw('0); drive_s_ar('0); drive_s_w('0); drive_m_b('0); drive_m_r('0);
    bus_s.aw_valid = 1'b0; bus_s.w_valid = 1'b0; bus_s.ar_valid = 1'b0;
    bus_s.b_ready  = 1'b0; bus_s.r_ready = 1'b0;
    bus_m.aw_ready = 1'b0; bus_m.w_ready = 1'b0; bus_m.ar_ready = 1'b0;
    bus_m.b_valid  = 1'b0; bus_m.r_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (far_valids() !== 5'b0) begin
        bad++; $display("FAIL reset_valids cycle %0d: got %b want 00000", i, far_valids());
      end
      total++;
      if (near_readys() !== 5'b0) begin
        bad++; $display("FAIL reset_readys cycle %0d: got %b want 00000", i, near_readys());
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (near_readys() !== 5'b11111) begin
      bad++; $display("FAIL release_readys: got %b want 11111", near_readys());
    end
    total++;
    if (far_valids() !== 5'b0) begin
      bad++; $display("FAIL release_valids: got %b want 00000", far_valids());
    end
  endtask

  task automatic test_aw_passthrough();
    ax_t a;
    a = rand_ax();
    a.id = 8'h5A; a.addr = 48'h0000_1234_5678; a.len = 8'd3; a.burst = 2'b01;
    bus_m.aw_ready = 1'b0;
    drive_s_aw(a);
    bus_s.aw_valid = 1'b1;
    total++;
    if (bus_s.aw_ready !== 1'b1 || bus_m.aw_valid !== 1'b0) begin
      bad++; $display("FAIL aw_pre: got ready=%b mvalid=%b want 1 0", bus_s.aw_ready, bus_m.aw_valid);
    end
    step();
    bus_s.aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus_m.aw_valid !== 1'b1 || get_m_aw() !== a) begin
        bad++; $display("FAIL aw_out cycle %0d: got v=%b %h want v=1 %h", i, bus_m.aw_valid, get_m_aw(), a);
      end
      if (i == 0) step();
    end
    bus_m.aw_ready = 1'b1;
    step();
    total++;
    if (bus_m.aw_valid !== 1'b0) begin
      bad++; $display("FAIL aw_drop: got %b want 0", bus_m.aw_valid);
    end
  endtask

  task automatic test_w_streaming();
    w_t w;
    bus_m.w_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w.data = 64'(i); w.strb = 8'hFF; w.last = (i == 15); w.user = 1'($urandom);
      drive_s_w(w);
      bus_s.w_valid = 1'b1;
      total++;
      if (bus_s.w_ready !== 1'b1) begin
        bad++; $display("FAIL w_ready beat %0d: got %b want 1", i, bus_s.w_ready);
      end
      step();
      total++;
      if (bus_m.w_valid !== 1'b1 || get_m_w() !== w) begin
        bad++; $display("FAIL w_stream beat %0d: got v=%b %h want v=1 %h", i, bus_m.w_valid, get_m_w(), w);
      end
    end
    bus_s.w_valid = 1'b0;
    step();
    total++;
    if (bus_m.w_valid !== 1'b0) begin
      bad++; $display("FAIL w_end: got %b want 0", bus_m.w_valid);
    end
  endtask

  task automatic test_r_backpressure();
    r_t q[$];
    r_t beat;
    int sent = 0;
    int recv = 0;
    logic in_f, out_f;
    logic [63:0] got;
    bus_s.r_ready = 1'b0;
    bus_m.r_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      if (!bus_m.r_valid && sent < 10) begin
        beat.id = 8'($urandom); beat.data = 64'(sent); beat.resp = 2'($urandom);
        beat.last = (sent == 9); beat.user = 1'($urandom);
        drive_m_r(beat);
        bus_m.r_valid = 1'b1;
      end
      bus_s.r_ready = 1'($urandom_range(0, 1));
      total++;
      if (bus_m.r_ready !== (q.size() < 2)) begin
        bad++; $display("FAIL r_ready cycle %0d: got %b want %b", cyc, bus_m.r_ready, q.size() < 2);
      end
      total++;
      if (bus_s.r_valid !== (q.size() > 0)) begin
        bad++; $display("FAIL r_valid cycle %0d: got %b want %b", cyc, bus_s.r_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        total++;
        if (get_s_r() !== q[0]) begin
          bad++; $display("FAIL r_payload cycle %0d: got %h want %h", cyc, get_s_r(), q[0]);
        end
      end
      in_f  = bus_m.r_valid & bus_m.r_ready;
      out_f = bus_s.r_valid & bus_s.r_ready;
      got   = bus_s.r_data;
      step();
      if (out_f) begin
        total++;
        if (got !== 64'(recv)) begin
          bad++; $display("FAIL r_order: got %0d want %0d", got, recv);
        end
        recv++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_f) begin
        q.push_back(beat);
        sent++;
        bus_m.r_valid = 1'b0;
      end
    end
    total++;
    if (recv !== 10) begin
      bad++; $display("FAIL r_count: got %0d want 10", recv);
    end
    bus_s.r_ready = 1'b0;
  endtask

  task automatic test_ar_skid();
    ax_t ex[3];
    int k = 0;
    logic sf;
    for (int i = 0; i < 3; i++) ex[i] = rand_ax();
    bus_m.ar_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_s_ar(ex[i]);
      bus_s.ar_valid = 1'b1;
      total++;
      if (bus_s.ar_ready !== 1'b1) begin
        bad++; $display("FAIL ar_accept beat %0d: got %b want 1", i, bus_s.ar_ready);
      end
      step();
    end
    drive_s_ar(ex[2]);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus_s.ar_ready !== 1'b0) begin
        bad++; $display("FAIL ar_full cycle %0d: got %b want 0", i, bus_s.ar_ready);
      end
      total++;
      if (bus_m.ar_valid !== 1'b1 || get_m_ar() !== ex[0]) begin
        bad++; $display("FAIL ar_hold cycle %0d: got v=%b %h want v=1 %h", i, bus_m.ar_valid, get_m_ar(), ex[0]);
      end
      step();
    end
    bus_m.ar_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
      sf = bus_s.ar_valid & bus_s.ar_ready;
      if (bus_m.ar_valid) begin
        total++;
        if (get_m_ar() !== ex[k]) begin
          bad++; $display("FAIL ar_order beat %0d: got %h want %h", k, get_m_ar(), ex[k]);
        end
        k++;
      end
      step();
      if (sf) bus_s.ar_valid = 1'b0;
    end
    total++;
    if (k !== 3 || bus_m.ar_valid !== 1'b0 || bus_s.ar_valid !== 1'b0) begin
      bad++; $display("FAIL ar_drain: got beats=%0d mvalid=%b svalid=%b want 3 0 0", k, bus_m.ar_valid, bus_s.ar_valid);
    end
  endtask

  task automatic test_b_reset_mid();
    b_t b0, b1;
    b0 = 11'($urandom); b1 = 11'($urandom);
    bus_s.b_ready = 1'b0;
    drive_m_b(b0);
    bus_m.b_valid = 1'b1;
    step();
    drive_m_b(b1);
    step();
    bus_m.b_valid = 1'b0;
    total++;
    if (bus_s.b_valid !== 1'b1 || get_s_b() !== b0 || bus_m.b_ready !== 1'b0) begin
      bad++; $display("FAIL b_full: got v=%b %h rdy=%b want v=1 %h rdy=0", bus_s.b_valid, get_s_b(), bus_m.b_ready, b0);
    end
    rst = 1'b1;
    step();
    total++;
    if (bus_s.b_valid !== 1'b0 || bus_m.b_ready !== 1'b0) begin
      bad++; $display("FAIL b_reset: got v=%b rdy=%b want 0 0", bus_s.b_valid, bus_m.b_ready);
    end
    rst = 1'b0;
    step();
    total++;
    if (near_readys() !== 5'b11111) begin
      bad++; $display("FAIL b_release_readys: got %b want 11111", near_readys());
    end
    bus_s.b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus_s.b_valid !== 1'b0) begin
        bad++; $display("FAIL b_stale cycle %0d: got %b want 0", i, bus_s.b_valid);
      end
      step();
    end
  endtask

  task automatic test_random_w_b();
    w_t wq[$];
    b_t bq[$];
    w_t wn;
    b_t bn;
    logic wi, wo, bi, bo;
    bus_s.w_valid = 1'b0;
    bus_m.b_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus_s.w_valid && $urandom_range(0, 3) != 0) begin
        wn = {$urandom, $urandom, 10'($urandom)};
        drive_s_w(wn);
        bus_s.w_valid = 1'b1;
      end
      if (!bus_m.b_valid && $urandom_range(0, 3) != 0) begin
        bn = 11'($urandom);
        drive_m_b(bn);
        bus_m.b_valid = 1'b1;
      end
      bus_m.w_ready = ($urandom_range(0, 2) != 0);
      bus_s.b_ready = ($urandom_range(0, 2) != 0);
      total++;
      if (bus_s.w_ready !== (wq.size() < 2) || bus_m.w_valid !== (wq.size() > 0)) begin
        bad++; $display("FAIL rnd_w_ctrl cycle %0d: got rdy=%b v=%b want rdy=%b v=%b",
                        cyc, bus_s.w_ready, bus_m.w_valid, wq.size() < 2, wq.size() > 0);
      end
      if (wq.size() > 0) begin
        total++;
        if (get_m_w() !== wq[0]) begin
          bad++; $display("FAIL rnd_w_data cycle %0d: got %h want %h", cyc, get_m_w(), wq[0]);
        end
      end
      total++;
      if (bus_m.b_ready !== (bq.size() < 2) || bus_s.b_valid !== (bq.size() > 0)) begin
        bad++; $display("FAIL rnd_b_ctrl cycle %0d: got rdy=%b v=%b want rdy=%b v=%b",
                        cyc, bus_m.b_ready, bus_s.b_valid, bq.size() < 2, bq.size() > 0);
      end
      if (bq.size() > 0) begin
        total++;
        if (get_s_b() !== bq[0]) begin
          bad++; $display("FAIL rnd_b_data cycle %0d: got %h want %h", cyc, get_s_b(), bq[0]);
        end
      end
      wi = bus_s.w_valid & bus_s.w_ready;
      wo = bus_m.w_valid & bus_m.w_ready;
      bi = bus_m.b_valid & bus_m.b_ready;
      bo = bus_s.b_valid & bus_s.b_ready;
      step();
      if (wo && wq.size() > 0) void'(wq.pop_front());
      if (bo && bq.size() > 0) void'(bq.pop_front());
      if (wi) begin wq.push_back(wn); bus_s.w_valid = 1'b0; end
      if (bi) begin bq.push_back(bn); bus_m.b_valid = 1'b0; end
    end
    bus_s.w_valid = 1'b0;
    bus_m.b_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_inputs();
    test_reset();
    test_aw_passthrough();
    test_w_streaming();
    test_r_backpressure();
    test_ar_skid();
    test_b_reset_mid();
    test_random_w_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
